serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_sub_pkg.sv | 17 +
 rtl/full_subtractor_cell.sv | 13 +
 rtl/serial_subtractor.sv | 122 ++++++++++++
 tb/tb_serial_subtractor.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared FSM encoding, width default and counter sizing for serial_subtractor
package serial_sub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int WIDTH_DEFAULT = 32;

   // Bit counter must hold 0..w-1; keep at least one bit for w=2.
   function automatic int cnt_width(input int w);
      return (w <= 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/full_subtractor_cell.sv
// rtl/full_subtractor_cell.sv - combinational one-bit full subtractor (a - b - bi)
module full_subtractor_cell (
   output logic d,
   output logic bo,
   input  logic a,
   input  logic b,
   input  logic bi
);

   assign d  = a ^ b ^ bi;
   assign bo = (~a & b) | (~a & bi) | (b & bi);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a - b - bin, LSB first; optional ovf output under SERIAL_SUB_OVERFLOW_EN
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
`ifdef SERIAL_SUB_OVERFLOW_EN
   ,
   output logic             ovf
`endif
);

   localparam int CW = cnt_width(WIDTH);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, diff_q, diff_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             br_q, br_d, bout_q, bout_d;
   logic             busy_q, done_q;
   logic             cell_d, cell_bo;
`ifdef SERIAL_SUB_OVERFLOW_EN
   logic             ovf_q, ovf_d;
`endif

   full_subtractor_cell u_cell (
      .d  (cell_d),
      .bo (cell_bo),
      .a  (a_q[0]),
      .b  (b_q[0]),
      .bi (br_q)
   );

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      diff_d  = diff_q;
      cnt_d   = cnt_q;
      br_d    = br_q;
      bout_d  = bout_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
      ovf_d   = ovf_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               a_d     = a;
               b_d     = b;
               br_d    = bin;
               cnt_d   = '0;
            end
         end
         RUN: begin
            a_d    = a_q >> 1;
            b_d    = b_q >> 1;
            br_d   = cell_bo;
            diff_d = {cell_d, diff_q[WIDTH-1:1]};
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d = DONE;
               bout_d  = cell_bo;
`ifdef SERIAL_SUB_OVERFLOW_EN
               // On the last bit the shift registers hold the operand MSBs.
               ovf_d   = (a_q[0] != b_q[0]) && (cell_d != a_q[0]);
`endif
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         diff_q  <= '0;
         cnt_q   <= '0;
         br_q    <= 1'b0;
         bout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         diff_q  <= diff_d;
         cnt_q   <= cnt_d;
         br_q    <= br_d;
         bout_q  <= bout_d;
         busy_q  <= (state_d == RUN);
         done_q  <= (state_d == DONE);
`ifdef SERIAL_SUB_OVERFLOW_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign diff = diff_q;
   assign bout = bout_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
   assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - scoreboard bench for serial_subtractor at WIDTH=8
module tb_serial_subtractor;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         bin = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         busy, done, bout;
   logic [W-1:0] diff;
`ifdef SERIAL_SUB_OVERFLOW_EN
   logic         ovf;
`endif

   typedef struct {
      logic [W-1:0] diff;
      logic         bout;
      logic         ovf;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   exp_t last_e;
   int   n_checks = 0;
   int   n_pass   = 0;
   int   n_done   = 0;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .bin   (bin),
      .busy  (busy),
      .done  (done),
      .diff  (diff),
      .bout  (bout)
`ifdef SERIAL_SUB_OVERFLOW_EN
      ,
      .ovf   (ovf)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin);
      exp_t        e;
      logic [W:0]  r;
      r      = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mbin};
      e.diff = r[W-1:0];
      e.bout = r[W];
      e.ovf  = (ma[W-1] != mb[W-1]) && (e.diff[W-1] != ma[W-1]);
      return e;
   endfunction

   always @(negedge clk) begin
      if (done) begin
         n_done++;
         if (sb.size() == 0) begin
            check("unexpected_done", 64'd1, 64'd0);
         end else begin
            mon_e = sb.pop_front();
            check("diff", 64'(diff), 64'(mon_e.diff));
            check("bout", 64'(bout), 64'(mon_e.bout));
`ifdef SERIAL_SUB_OVERFLOW_EN
            check("ovf", 64'(ovf), 64'(mon_e.ovf));
`endif
            last_e = mon_e;
         end
      end
   end

   task automatic wait_done(output int cycles);
      cycles = 0;
      while (!done && cycles < 30) begin
         @(negedge clk);
         cycles++;
      end
   endtask

   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin);
      int cyc;
      a     = ta;
      b     = tb;
      bin   = tbin;
      start = 1'b1;
      sb.push_back(model(ta, tb, tbin));
      @(negedge clk);
      start = 1'b0;
      a     = ~ta;
      b     = ~tb;
      check("busy_run", 64'(busy), 64'd1);
      wait_done(cyc);
      check("latency", 64'(cyc), 64'(W));
      @(negedge clk);
      check("done_one_cycle", 64'(done), 64'd0);
      check("busy_idle", 64'(busy), 64'd0);
      @(negedge clk);
      check("diff_hold", 64'(diff), 64'(last_e.diff));
      check("bout_hold", 64'(bout), 64'(last_e.bout));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int cyc;
      int d0;

      repeat (3) @(negedge clk);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_diff", 64'(diff), 64'd0);
      check("rst_bout", 64'(bout), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      run_op(8'h05, 8'h03, 1'b0);
      run_op(8'h03, 8'h05, 1'b0);
      run_op(8'h00, 8'h00, 1'b1);
      run_op(8'h80, 8'h01, 1'b0);
      run_op(8'hFF, 8'hFF, 1'b1);
      for (int i = 0; i < 6; i++)
         run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));

      // start held high, operand changed mid-RUN, second op only after DONE
      d0    = n_done;
      a     = 8'h10;
      b     = 8'h01;
      bin   = 1'b0;
      start = 1'b1;
      sb.push_back(model(8'h10, 8'h01, 1'b0));
      @(negedge clk);
      check("held_busy", 64'(busy), 64'd1);
      repeat (3) @(negedge clk);
      a = 8'hFF;
      sb.push_back(model(8'hFF, 8'h01, 1'b0));
      wait_done(cyc);
      check("held_latency", 64'(cyc), 64'(W - 3));
      @(negedge clk);
      check("held_idle_after_done", 64'(busy), 64'd0);
      @(negedge clk);
      check("held_second_accept", 64'(busy), 64'd1);
      start = 1'b0;
      wait_done(cyc);
      @(negedge clk);
      check("held_done_count", 64'(n_done - d0), 64'd2);

      // reset wins over start on the same edge
      rst_n = 1'b0;
      start = 1'b1;
      a     = 8'h22;
      b     = 8'h11;
      @(negedge clk);
      check("rst_vs_start_busy", 64'(busy), 64'd0);
      rst_n = 1'b1;
      start = 1'b0;
      @(negedge clk);
      check("rst_vs_start_idle", 64'(busy), 64'd0);

      // abort mid-RUN just before bit 4 is processed
      d0    = n_done;
      a     = 8'h55;
      b     = 8'h22;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      check("abort_busy_before", 64'(busy), 64'd1);
      rst_n = 1'b0;
      @(negedge clk);
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_diff", 64'(diff), 64'd0);
      check("abort_bout", 64'(bout), 64'd0);
      check("abort_done", 64'(done), 64'd0);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      check("abort_no_done", 64'(n_done - d0), 64'd0);
      run_op(8'h55, 8'h22, 1'b0);

      check("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
